gskew_param_predictor: RTL and testbench

Parametrised three-bank gskew branch predictor: bimodal, gselect and gshare pattern tables of 2-bit saturating counters, combined by majority vote. It holds its own speculative global history register (GHR) and trains from a resolve/update port driven by the execute stage. It clears its tables with a hardware init sweep after reset. It sits between fetch (`pred_*` request side) and execute (`upd_*` resolve side) in the branch-prediction path.

---
 rtl/gskew_param_predictor.sv | 180 ++++++++++++++++++
 tb/tb_gskew_param_predictor.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/gskew_param_predictor.sv
// gskew_param_predictor: three-bank gskew branch predictor with bimodal,
// gshare and gselect tables of 2-bit saturating counters. The three bank
// votes are combined by majority.
// The predictor keeps its own speculative global history register. It trains
// from the execute-stage resolve port. After reset, a hardware sweep
// initialises every table entry.
// Optional feature: define GSKEW_PARTIAL_UPDATE_EN to train only the banks
// that voted correctly when the overall prediction was right.
module gskew_param_predictor #(
  parameter int PC_W   = 8,
  parameter int HIST_W = 8,
  parameter int IDX_W  = 6
) (
  input  logic              clk,
  input  logic              reset,
  output logic              ready,
  input  logic              pred_req,
  input  logic [PC_W-1:0]   pred_pc,
  output logic              pred_valid,
  output logic              pred_taken,
  output logic [HIST_W-1:0] pred_ghr,
  input  logic              upd_valid,
  input  logic [PC_W-1:0]   upd_pc,
  input  logic [HIST_W-1:0] upd_ghr,
  input  logic              upd_pred,
  input  logic              upd_taken,
  output logic              mispredict
);

  localparam int unsigned DEPTH = 2 ** IDX_W;
  localparam int          G     = IDX_W / 2;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    cnt_q, cnt_d;
  logic [HIST_W-1:0]   ghr_q, ghr_d;
  logic                pred_valid_q, pred_valid_d;
  logic                pred_taken_q, pred_taken_d;
  logic [HIST_W-1:0]   pred_ghr_q, pred_ghr_d;
  logic                mispredict_q, mispredict_d;

  logic [1:0]          bim_q  [DEPTH];
  logic [1:0]          gsh_q  [DEPTH];
  logic [1:0]          gsel_q [DEPTH];

  logic                init_we, upd_we;
  logic [IDX_W-1:0]    p_bim_idx, p_gsh_idx, p_gsel_idx;
  logic [IDX_W-1:0]    u_bim_idx, u_gsh_idx, u_gsel_idx;
  logic [1:0]          u_bim_cur, u_gsh_cur, u_gsel_cur;
  logic                pred_taken_comb, upd_mis;
  logic                train_bim, train_gsh, train_gsel;
  logic                unused_hi;

  function automatic logic [IDX_W-1:0] idx_gsel(input logic [PC_W-1:0] pc,
                                                input logic [HIST_W-1:0] ghr);
    return {pc[IDX_W-G-1:0], ghr[G-1:0]};
  endfunction

  function automatic logic [1:0] sat2(input logic [1:0] c, input logic t);
    if (t) return (c == 2'b11) ? c : c + 2'b01;
    return (c == 2'b00) ? c : c - 2'b01;
  endfunction

  // The upper PC and history bits feed no index. They are gathered here so
  // that it is clear they are left unused on purpose.
  assign unused_hi = ^{pred_pc, upd_pc, upd_ghr};

  // Compute the lookup indices and the majority vote from the pre-edge tables.
  always_comb begin
    p_bim_idx       = pred_pc[IDX_W-1:0];
    p_gsh_idx       = pred_pc[IDX_W-1:0] ^ ghr_q[IDX_W-1:0];
    p_gsel_idx      = idx_gsel(pred_pc, ghr_q);
    pred_taken_comb = (bim_q[p_bim_idx][1] & gsh_q[p_gsh_idx][1]) |
                      (bim_q[p_bim_idx][1] & gsel_q[p_gsel_idx][1]) |
                      (gsh_q[p_gsh_idx][1] & gsel_q[p_gsel_idx][1]);
  end

  // Compute the update indices, the current counters and the per-bank
  // training enables.
  always_comb begin
    u_bim_idx  = upd_pc[IDX_W-1:0];
    u_gsh_idx  = upd_pc[IDX_W-1:0] ^ upd_ghr[IDX_W-1:0];
    u_gsel_idx = idx_gsel(upd_pc, upd_ghr);
    u_bim_cur  = bim_q[u_bim_idx];
    u_gsh_cur  = gsh_q[u_gsh_idx];
    u_gsel_cur = gsel_q[u_gsel_idx];
    upd_mis    = upd_valid & (upd_pred ^ upd_taken);
`ifdef GSKEW_PARTIAL_UPDATE_EN
    train_bim  = upd_mis | (u_bim_cur[1] == upd_taken);
    train_gsh  = upd_mis | (u_gsh_cur[1] == upd_taken);
    train_gsel = upd_mis | (u_gsel_cur[1] == upd_taken);
`else
    train_bim  = 1'b1;
    train_gsh  = 1'b1;
    train_gsel = 1'b1;
`endif
  end

  // Compute the next state: the init sweep, the prediction issue and the
  // speculative history with its repair.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ghr_d        = ghr_q;
    pred_valid_d = 1'b0;
    pred_taken_d = pred_taken_q;
    pred_ghr_d   = pred_ghr_q;
    mispredict_d = 1'b0;
    init_we      = 1'b0;
    upd_we       = 1'b0;
    unique case (state_q)
      ST_INIT: begin
        init_we = 1'b1;
        cnt_d   = cnt_q + IDX_W'(1);
        if (cnt_q == '1) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (pred_req) begin
          pred_valid_d = 1'b1;
          pred_taken_d = pred_taken_comb;
          pred_ghr_d   = ghr_q;
          ghr_d        = {ghr_q[HIST_W-2:0], pred_taken_comb};
        end
        if (upd_valid) begin
          upd_we       = 1'b1;
          mispredict_d = upd_mis;
          // A repair overrides any speculative shift from this cycle.
          if (upd_mis) ghr_d = {upd_ghr[HIST_W-2:0], upd_taken};
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  // Register the control state and the outputs, with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_INIT;
      cnt_q        <= '0;
      ghr_q        <= '0;
      pred_valid_q <= 1'b0;
      pred_taken_q <= 1'b0;
      pred_ghr_q   <= '0;
      mispredict_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ghr_q        <= ghr_d;
      pred_valid_q <= pred_valid_d;
      pred_taken_q <= pred_taken_d;
      pred_ghr_q   <= pred_ghr_d;
      mispredict_q <= mispredict_d;
    end
  end

  // Write the counter tables. The init write comes last so that it wins any
  // same-entry conflict.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (upd_we) begin
        if (train_bim)  bim_q[u_bim_idx]   <= sat2(u_bim_cur, upd_taken);
        if (train_gsh)  gsh_q[u_gsh_idx]   <= sat2(u_gsh_cur, upd_taken);
        if (train_gsel) gsel_q[u_gsel_idx] <= sat2(u_gsel_cur, upd_taken);
      end
      if (init_we) begin
        bim_q[cnt_q]  <= 2'b01;
        gsh_q[cnt_q]  <= 2'b01;
        gsel_q[cnt_q] <= 2'b01;
      end
    end
  end

  assign ready      = (state_q == ST_RUN);
  assign pred_valid = pred_valid_q;
  assign pred_taken = pred_taken_q;
  assign pred_ghr   = pred_ghr_q;
  assign mispredict = mispredict_q;

endmodule

// File: tb/tb_gskew_param_predictor.sv
// Testbench for gskew_param_predictor. A behavioural model holds the tables
// as integer arrays and the history as an integer. A compare process checks
// the outputs at every negedge. Directed steps also carry hand-computed
// literal expectations.
module tb_gskew_param_predictor;

  localparam int PC_W   = 8;
  localparam int HIST_W = 8;
  localparam int IDX_W  = 6;
  localparam int N      = 1 << IDX_W;
  localparam int HN     = 1 << HIST_W;
  localparam int GL     = 1 << (IDX_W / 2);
  localparam int GH     = 1 << (IDX_W - IDX_W / 2);
`ifdef GSKEW_PARTIAL_UPDATE_EN
  localparam bit PARTIAL = 1'b1;
`else
  localparam bit PARTIAL = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset, pred_req, upd_valid, upd_pred, upd_taken;
  logic [PC_W-1:0]   pred_pc, upd_pc;
  logic [HIST_W-1:0] upd_ghr;
  logic              ready, pred_valid, pred_taken, mispredict;
  logic [HIST_W-1:0] pred_ghr;

  int errors = 0;
  int checks = 0;

  int bim [N];
  int gsh [N];
  int gsel[N];
  int m_ghr, m_cnt;
  bit m_run, started;
  bit exp_ready, exp_pv, exp_pt, exp_mis;
  int exp_pg;

  gskew_param_predictor #(.PC_W(PC_W), .HIST_W(HIST_W), .IDX_W(IDX_W)) dut (
    .clk(clk), .reset(reset), .ready(ready),
    .pred_req(pred_req), .pred_pc(pred_pc), .pred_valid(pred_valid),
    .pred_taken(pred_taken), .pred_ghr(pred_ghr),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_ghr(upd_ghr),
    .upd_pred(upd_pred), .upd_taken(upd_taken), .mispredict(mispredict)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int ib(int pc);          return pc % N; endfunction
  function automatic int is(int pc, int h);   return (pc ^ h) % N; endfunction
  function automatic int ig(int pc, int h);   return (pc % GH) * GL + (h % GL); endfunction
  function automatic int vote(int c);         return (c >= 2) ? 1 : 0; endfunction

  function automatic int train(int c, bit t, bit mis);
    if (PARTIAL && !mis && (vote(c) != int'(t))) return c;
    if (t) return (c == 3) ? 3 : c + 1;
    return (c == 0) ? 0 : c - 1;
  endfunction

  task automatic model_step();
    int nb, ns, ng, nxt;
    bit mis;
    if (reset) begin
      m_run = 0; m_cnt = 0; m_ghr = 0; started = 1;
      exp_pv = 0; exp_pt = 0; exp_pg = 0; exp_mis = 0;
    end else if (!m_run) begin
      bim[m_cnt] = 1; gsh[m_cnt] = 1; gsel[m_cnt] = 1;
      m_cnt++;
      if (m_cnt == N) m_run = 1;
      exp_pv = 0; exp_mis = 0;
    end else begin
      nxt = m_ghr; exp_pv = 0; exp_mis = 0;
      if (pred_req) begin
        nb = ib(int'(pred_pc)); ns = is(int'(pred_pc), m_ghr); ng = ig(int'(pred_pc), m_ghr);
        exp_pv = 1;
        exp_pt = (vote(bim[nb]) + vote(gsh[ns]) + vote(gsel[ng])) >= 2;
        exp_pg = m_ghr;
        nxt = (m_ghr * 2 + int'(exp_pt)) % HN;
      end
      if (upd_valid) begin
        mis = (upd_pred != upd_taken);
        exp_mis = mis;
        nb = ib(int'(upd_pc)); ns = is(int'(upd_pc), int'(upd_ghr)); ng = ig(int'(upd_pc), int'(upd_ghr));
        bim[nb]  = train(bim[nb], upd_taken, mis);
        gsh[ns]  = train(gsh[ns], upd_taken, mis);
        gsel[ng] = train(gsel[ng], upd_taken, mis);
        if (mis) nxt = (int'(upd_ghr) * 2 + int'(upd_taken)) % HN;
      end
      m_ghr = nxt;
    end
    exp_ready = m_run;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (started) begin
      chk("ready", 32'(ready), 32'(exp_ready));
      chk("pred_valid", 32'(pred_valid), 32'(exp_pv));
      chk("mispredict", 32'(mispredict), 32'(exp_mis));
      if (exp_pv || !exp_ready) begin
        chk("pred_taken", 32'(pred_taken), 32'(exp_pt));
        chk("pred_ghr", 32'(pred_ghr), 32'(exp_pg));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic drive(input bit preq, input logic [7:0] ppc, input bit uv,
                       input logic [7:0] upc, input logic [7:0] ughr,
                       input bit up, input bit ut);
    pred_req = preq; pred_pc = ppc;
    upd_valid = uv; upd_pc = upc; upd_ghr = ughr; upd_pred = up; upd_taken = ut;
    @(posedge clk); #1;
    pred_req = 0; upd_valid = 0;
  endtask

  task automatic predict(input string name, input logic [7:0] pc,
                         input bit et, input logic [7:0] eg);
    drive(1, pc, 0, 8'h00, 8'h00, 0, 0);
    chk({name, "_valid"}, 32'(pred_valid), 32'd1);
    chk({name, "_taken"}, 32'(pred_taken), 32'(et));
    chk({name, "_ghr"}, 32'(pred_ghr), 32'(eg));
  endtask

  task automatic update(input string name, input logic [7:0] pc, input logic [7:0] ghr,
                        input bit up, input bit ut);
    drive(0, 8'h00, 1, pc, ghr, up, ut);
    chk(name, 32'(mispredict), 32'(up != ut));
  endtask

  // Count the cycles with ready low after reset is released. pred_req is held
  // high throughout to confirm that it is ignored.
  task automatic wait_ready(input string name);
    int n = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (ready === 1'b1) break;
      n++;
    end
    chk(name, 32'(n), 32'd64);
    pred_req = 0;
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1; pred_req = 0; pred_pc = 0; upd_valid = 0; upd_pc = 0;
    upd_ghr = 0; upd_pred = 0; upd_taken = 0;
    repeat (3) @(posedge clk);
    #1 reset = 0; pred_req = 1; pred_pc = 8'h15;
    wait_ready("init_len");

    predict("cold", 8'h15, 0, 8'h00);

    // Train pc 0x15 with history 0. Each mispredict repairs the history to 0x01.
    update("train1_mis", 8'h15, 8'h00, 0, 1);
    update("train2_mis", 8'h15, 8'h00, 0, 1);
    update("train3_mis", 8'h15, 8'h00, 1, 1);
    update("ghr_clear_mis", 8'h3F, 8'h80, 1, 0);   // repair -> 0x00
    predict("trained", 8'h15, 1, 8'h00);

    // Saturation: a wrapping counter would fall to not-taken here.
    update("sat1_mis", 8'h15, 8'h00, 1, 1);
    update("sat2_mis", 8'h15, 8'h00, 1, 1);
    update("sat_dec_mis", 8'h15, 8'h00, 1, 0);     // 3 -> 2, history -> 0x00
    predict("sat", 8'h15, 1, 8'h00);

    // Repair from a returned history.
    predict("rep_p1", 8'h00, 0, 8'h01);
    predict("rep_p2", 8'h00, 0, 8'h02);
    predict("rep_p3", 8'h00, 0, 8'h04);
    update("rep_mis", 8'h2A, 8'h05, 0, 1);
    predict("repair", 8'h00, 0, 8'h0B);

    // Simultaneous predict and mispredicting update: the old table and the
    // old history are used, and the repair value replaces the shift.
    drive(1, 8'h15, 1, 8'h15, 8'h16, 0, 1);
    chk("sim_valid", 32'(pred_valid), 32'd1);
    chk("sim_taken", 32'(pred_taken), 32'd0);
    chk("sim_ghr", 32'(pred_ghr), 32'h16);
    chk("sim_mis", 32'(mispredict), 32'd1);
    predict("after_sim", 8'h15, 0, 8'h2D);

    // Partial update: make gselect[40] vote not-taken, then apply correct
    // taken updates. A probe then isolates the gselect vote.
    update("pu_dec1", 8'h05, 8'h00, 1, 0);
    update("pu_dec2", 8'h05, 8'h00, 1, 0);
    update("pu_inc1", 8'h15, 8'h00, 1, 1);
    update("pu_inc2", 8'h15, 8'h00, 1, 1);
    update("pu_ghr", 8'h3F, 8'h04, 1, 0);          // history -> 0x08
    predict("partial_probe", 8'h15, !PARTIAL, 8'h08);

    // Reset in RUN with a request in flight, then reset again mid-INIT.
    reset = 1; pred_req = 1; pred_pc = 8'h15;
    @(posedge clk); #1;
    chk("rst_run_valid", 32'(pred_valid), 32'd0);
    chk("rst_run_ready", 32'(ready), 32'd0);
    reset = 0;
    repeat (10) @(posedge clk);
    #1 reset = 1;
    @(posedge clk); #1;
    reset = 0;
    wait_ready("reinit_len");
    predict("post_reinit", 8'h15, 0, 8'h00);

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
